// File: rtl/fifo_selftest.sv
// fifo_selftest: synchronous FIFO with built-in pattern writer, reader and data checker.
// Ports:
//   sys_clk_i, sys_rst_n_i      clock, asynchronous active-low reset
//   start_i, mode_i             run request (ignored while busy); 0 = burst, 1 = streaming
//   err_inject_i                flips bit 0 of the next written word
//   busy_o, done_o, pass_o      run status; pass_o holds until the next accepted start
//   err_cnt_o                   saturating count of mismatched words
//   level_o, full_o, empty_o, almost_full_o, almost_empty_o   registered FIFO status
//   overflow_o, underflow_o     sticky illegal-access flags, cleared by start
module fifo_selftest #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ROUNDS   = 2,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_n_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     err_inject_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [15:0]              err_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int TOTAL = ROUNDS * DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] TOT  = CW'(TOTAL);
  localparam logic [AW:0]   LV_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE = (AW+1)'(AE_LEVEL);

  typedef enum logic [1:0] {W_IDLE, W_RUN, W_HOLD, W_DONE} w_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RUN, R_DONE} r_t;

  w_t ws_q, ws_d;
  r_t rs_q, rs_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, wpat_q, wpat_d, exp_q, exp_d, wdata;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, lvl_q, lvl_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [15:0] err_q, err_d;
  logic full_q, empty_q, af_q, ae_q;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic inj_q, inj_d, chk_q, last_q, last_d, ovf_q, ovf_d, udf_q, udf_d;
  logic start_ok, wr_req, rd_req, wr_ok, rd_ok, inj;

  always_comb begin
    start_ok = start_i & ~busy_q;
    // burst writes are not gated by full so a controller fault surfaces as overflow
    wr_req = (ws_q == W_RUN) && (!mode_q || !full_q);
    rd_req = (rs_q == R_RUN) && !empty_q;
    wr_ok = wr_req && !full_q;
    rd_ok = rd_req && !empty_q;
    inj = inj_q | err_inject_i;
    wdata = {wpat_q[DATA_W-1:1], wpat_q[0] ^ inj};
    wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};
    lvl_d = wptr_d - rptr_d;
    wcnt_d = start_ok ? '0 : wr_ok ? wcnt_q + 1'b1 : wcnt_q;
    rcnt_d = start_ok ? '0 : rd_ok ? rcnt_q + 1'b1 : rcnt_q;
    wpat_d = start_ok ? '0 : wr_ok ? wpat_q + 1'b1 : wpat_q;
    exp_d = start_ok ? '0 : chk_q ? exp_q + 1'b1 : exp_q;
    last_d = rd_ok && (rcnt_q == LAST);
    done_d = chk_q && last_q;
    err_d = start_ok ? '0 : (chk_q && rdata_q != exp_q && err_q != '1) ? err_q + 16'd1 : err_q;
    busy_d = start_ok ? 1'b1 : done_d ? 1'b0 : busy_q;
    pass_d = start_ok ? 1'b0 : done_d ? (err_d == '0) : pass_q;
    mode_d = start_ok ? mode_i : mode_q;
    inj_d = wr_ok ? 1'b0 : inj;
    ovf_d = start_ok ? 1'b0 : ovf_q | (wr_req && full_q);
    udf_d = start_ok ? 1'b0 : udf_q | (rd_req && empty_q);
  end

  always_comb begin
    ws_d = ws_q;
    case (ws_q)
      W_RUN:  ws_d = (wr_ok && mode_q && wcnt_q == LAST) ? W_DONE :
                     (wr_ok && !mode_q && &wcnt_q[AW-1:0]) ? W_HOLD : W_RUN;
      W_HOLD: ws_d = !empty_q ? W_HOLD : (wcnt_q == TOT) ? W_DONE : W_RUN;
      default: ws_d = start_ok ? W_RUN : busy_q ? ws_q : W_IDLE;
    endcase
  end

  always_comb begin
    rs_d = rs_q;
    case (rs_q)
      R_WAIT: rs_d = full_q ? R_RUN : R_WAIT;
      R_RUN:  rs_d = last_d ? R_DONE : (!mode_q && empty_q) ? R_WAIT : R_RUN;
      default: rs_d = start_ok ? (mode_i ? R_RUN : R_WAIT) : busy_q ? rs_q : R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (wr_ok) mem[wptr_q[AW-1:0]] <= wdata;
    if (rd_ok) rdata_q <= mem[rptr_q[AW-1:0]];
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ws_q <= W_IDLE;
      rs_q <= R_IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      af_q <= 1'b0;
      ae_q <= 1'b1;
      wcnt_q <= '0;
      rcnt_q <= '0;
      wpat_q <= '0;
      exp_q <= '0;
      err_q <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      inj_q <= 1'b0;
      chk_q <= 1'b0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q <= lvl_d;
      full_q <= lvl_d == LV_FULL;
      empty_q <= lvl_d == '0;
      af_q <= lvl_d >= AF;
      ae_q <= lvl_d <= AE;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wpat_q <= wpat_d;
      exp_q <= exp_d;
      err_q <= err_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      inj_q <= inj_d;
      chk_q <= rd_ok;
      last_q <= last_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign err_cnt_o = err_q;
  assign level_o = lvl_q;
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign almost_full_o = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o = ovf_q;
  assign underflow_o = udf_q;
endmodule
